// File: rtl/dsa_seq_pkg.sv
// rtl/dsa_seq_pkg.sv - shared types and defaults for the sequential DSA output path
package dsa_seq_pkg;
    localparam int AW_DEF    = 19;
    localparam int DIM_W_DEF = 16;
    localparam int PIX_W     = 8;

    typedef logic [PIX_W-1:0]     pix_t;
    typedef logic [DIM_W_DEF-1:0] dim_t;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        RUN,
        FLUSH
    } stream_state_t;
endpackage

// File: rtl/dsa_fifo2.sv
// rtl/dsa_fifo2.sv - 2-entry synchronous FIFO decoupling RAM reads from the output stream
module dsa_fifo2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] head,
    output logic [1:0]   count
);
    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign head = mem[rd_ptr];
endmodule

// File: rtl/dsa_out_streamer.sv
// rtl/dsa_out_streamer.sv - streams the scaled frame from output RAM as a byte stream
// Optional running byte sum on checksum when STREAM_CHECKSUM_EN is defined.
module dsa_out_streamer #(
    parameter int AW    = dsa_seq_pkg::AW_DEF,
    parameter int DIM_W = dsa_seq_pkg::DIM_W_DEF,
    parameter int PIX_W = dsa_seq_pkg::PIX_W
) (
    input  logic             clk_50,
    input  logic             rst_n,
    input  logic             start,
    input  logic [DIM_W-1:0] out_w,
    input  logic [DIM_W-1:0] out_h,
    output logic             mem_rd,
    output logic [AW-1:0]    mem_addr,
    input  logic [PIX_W-1:0] mem_rdata,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [PIX_W-1:0] m_data,
    output logic             m_sof,
    output logic             m_last,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [15:0]      checksum
);
    import dsa_seq_pkg::*;

    localparam int TW = 2 * DIM_W;
    localparam logic [TW:0] DEPTH_V = {{TW{1'b0}}, 1'b1} << AW;

    stream_state_t state, state_nx;
    logic [TW-1:0] total, rd_cnt, beat_cnt, beat_nx;
    logic          inflight, done_q, err_q, done_nx, err_nx;
    logic          pop, rd_issue, accept_start;
    logic [1:0]    fifo_count;

    assign pop     = m_valid & m_ready;
    assign beat_nx = beat_cnt + TW'(pop);
    // done_q high means the frame just ended; a start in that cycle is dropped
    assign accept_start = start && (state == IDLE) && !done_q;

    always_comb begin
        state_nx = state;
        rd_issue = 1'b0;
        done_nx  = 1'b0;
        err_nx   = 1'b0;
        case (state)
            IDLE: begin
                if (accept_start) state_nx = CHECK;
            end
            CHECK: begin
                if (total == '0) begin
                    done_nx  = 1'b1;
                    state_nx = IDLE;
                end else if ({1'b0, total} > DEPTH_V) begin
                    done_nx  = 1'b1;
                    err_nx   = 1'b1;
                    state_nx = IDLE;
                end else begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                // occupancy after this edge must leave room for the read now in flight
                rd_issue = ({1'b0, fifo_count} + {2'b0, inflight}) < (3'd2 + {2'b0, pop});
                if (rd_issue && (rd_cnt + 1'b1 == total)) state_nx = FLUSH;
            end
            FLUSH: begin
                if (beat_nx == total) begin
                    done_nx  = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            total    <= '0;
            rd_cnt   <= '0;
            beat_cnt <= '0;
            inflight <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_nx;
            done_q   <= done_nx;
            err_q    <= err_nx;
            inflight <= rd_issue;
            if (accept_start) total <= TW'(out_w) * TW'(out_h);
            if (state == CHECK) begin
                rd_cnt   <= '0;
                beat_cnt <= '0;
            end else begin
                if (rd_issue) rd_cnt <= rd_cnt + 1'b1;
                beat_cnt <= beat_nx;
            end
        end
    end

    dsa_fifo2 #(.W(PIX_W)) u_fifo (
        .clk   (clk_50),
        .rst_n (rst_n),
        .push  (inflight),
        .pop   (pop),
        .wdata (mem_rdata),
        .head  (m_data),
        .count (fifo_count)
    );

    assign m_valid  = (fifo_count != 2'd0);
    assign m_sof    = m_valid && (beat_cnt == '0);
    assign m_last   = m_valid && (beat_cnt == total - 1'b1);
    assign mem_rd   = rd_issue;
    assign mem_addr = rd_cnt[AW-1:0];
    assign busy     = (state != IDLE);
    assign done     = done_q;
    assign err      = err_q;

`ifdef STREAM_CHECKSUM_EN
    logic [15:0] sum;
    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) sum <= '0;
        else if (accept_start) sum <= '0;
        else if (pop) sum <= sum + 16'(m_data);
    end
    assign checksum = sum;
`else
    assign checksum = 16'h0000;
`endif
endmodule

// File: doc/dsa_out_streamer.md
Name: dsa_out_streamer

Overview:
- Downstream stage of the sequential bilinear DSA core. It consumes the scaled image the core leaves in the output RAM.
- When triggered by the core's done pulse, it reads the out_w x out_h pixels in row-major order and emits them as an 8-bit valid/ready byte stream, with start-of-frame and last flags.
- The stream feeds the frame-dump / host-link path. It replaces the simulation-only memory dump with synthesizable hardware.

Parameters:
- AW, 19, output RAM address width; DEPTH = 2**AW bytes.
- DIM_W, 16, width of the out_w / out_h dimension inputs.
- PIX_W, 8, pixel width in bits.

Ports:
- clk_50  in  1  system clock, 50 MHz.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse (core done); launches one frame.
- out_w  in  DIM_W  output width in pixels; sampled on start.
- out_h  in  DIM_W  output height in pixels; sampled on start.
- mem_rd  out  1  RAM read enable.
- mem_addr  out  AW  RAM read address.
- mem_rdata  in  PIX_W  RAM read data; valid exactly 1 cycle after mem_rd.
- m_valid  out  1  stream beat valid.
- m_ready  in  1  downstream ready.
- m_data  out  PIX_W  pixel byte.
- m_sof  out  1  first beat of the frame; qualified by m_valid.
- m_last  out  1  final beat of the frame; qualified by m_valid.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse at frame end.
- err  out  1  one-cycle pulse when the requested frame exceeds DEPTH.
- checksum  out  16  running byte sum; see Optional Feature.

Behaviour:
- Reset values: all outputs 0. Internal state: FSM in IDLE, FIFO empty, counters 0.
- Reset asserted mid-frame aborts immediately to the reset state. No done or err pulse is issued.
- FSM states: IDLE, CHECK, RUN, FLUSH.
  - IDLE: on start, latch out_w/out_h, compute total = out_w*out_h (2*DIM_W bits, registered), go to CHECK. busy goes high the cycle after start.
  - CHECK (1 cycle), evaluated in order:
    - total == 0 -> pulse done, return to IDLE.
    - total > DEPTH -> pulse err and done in the same cycle, return to IDLE.
    - otherwise -> RUN with rd_cnt = 0 and beat_cnt = 0.
  - RUN: issue reads at mem_addr = rd_cnt[AW-1:0], incrementing rd_cnt by 1 per read (row-major, contiguous). When rd_cnt reaches total, go to FLUSH.
  - FLUSH: wait until beat_cnt == total. Then pulse done, drop busy in the same cycle, go to IDLE.
- Read issue rule: assert mem_rd only when (fifo_count + inflight − pop) < 2, where pop = m_valid & m_ready in that cycle.
- Buffering:
  - Returned mem_rdata is pushed into a 2-entry FIFO on the cycle after mem_rd.
  - m_valid = FIFO non-empty; m_data = FIFO head.
- Latency: start in cycle 0 -> CHECK in cycle 1 -> first mem_rd in cycle 2 -> first m_valid in cycle 4.
- Throughput: sustained 1 beat/cycle when m_ready is held high.
- Handshake rules:
  - While m_valid is high and m_ready is low, m_data, m_sof and m_last hold stable.
  - No beat is dropped or duplicated under any m_ready pattern.
- Flags: m_sof = (beat_cnt == 0); m_last = (beat_cnt == total − 1). For a 1-pixel frame both are asserted on the same beat.
- start while busy is ignored, with no effect on the frame in flight.
- start in the same cycle as done is also ignored; a new frame needs a start pulse in IDLE.

Optional Feature:
- Macro: STREAM_CHECKSUM_EN.
- Defined:
  - checksum is cleared on the accepted start.
  - Each accepted beat adds m_data, zero-extended, modulo 2^16.
  - The value is stable from done until the next accepted start.
- Undefined: checksum is tied to 0 and no adder is synthesized.

Decomposition:
- Shared package dsa_seq_pkg:
  - AW_DEF = 19, DIM_W_DEF = 16, PIX_W = 8.
  - typedef pix_t (PIX_W bits), typedef dim_t (DIM_W bits).
  - enum stream_state_t {IDLE, CHECK, RUN, FLUSH}.
- One sub-module: dsa_fifo2, a 2-entry synchronous FIFO with push, pop, head, count (2 bits), and asynchronous active-low reset.

Test Plan:
- 4x2 frame, RAM[i] = i+1, m_ready = 1 -> 8 beats with data 01..08. m_sof on beat 0, m_last on beat 7, first m_valid 4 cycles after start, done one cycle after the last beat.
- Same frame with m_ready toggling in a pseudo-random pattern -> identical sequence 01..08, and data/flags stable while stalled.
- out_w = 0, out_h = 5 -> no mem_rd, no m_valid; done pulses 2 cycles after start; err = 0.
- AW = 4, frame 5x4 (20 > 16) -> err and done pulse together, no reads issued.
- rst_n low at beat 3 of a 64x64 frame, then a fresh start -> outputs return to 0 immediately; the new frame restarts at address 0 with m_sof. A start while busy in the new frame is ignored.
- With STREAM_CHECKSUM_EN, 4x2 frame 01..08 -> checksum = 0x0024 at done. Without the macro, checksum stays 0.
